asignador_posicion: RTL and testbench

- Requesting end of the random-position interface: on a request it pulses `pedir` toward the random-position counter and captures the returned 4-bit `posicion`.
- Keeps a 16-slot occupancy map. Retries while the drawn slot is busy, then grants a free slot with a one-cycle `listo` pulse.
- Sits between game/control logic and the random generator. Slots are released individually.

---
 rtl/asignador_posicion_pkg.sv | 29 ++
 rtl/asignador_posicion_if.sv | 33 +++
 rtl/asignador_posicion_mapa_ocupacion.sv | 48 ++++
 rtl/asignador_posicion.sv | 181 ++++++++++++++++++
 tb/tb_asignador_posicion.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/asignador_posicion_pkg.sv
// ---------------------------------------------------------------------------
// asignador_posicion_pkg
// Shared definitions for the slot allocator:
//   - POS_W / N_SLOTS : width of the position bus and size of the slot map
//   - estado_e        : allocator FSM states
//   - one_hot()       : index -> one-hot slot mask, used by both the release
//                       and the grant paths of the occupancy map
// ---------------------------------------------------------------------------
package asignador_posicion_pkg;

    localparam int POS_W   = 4;
    localparam int N_SLOTS = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PEDIR   = 3'd1,
        CAPTURA = 3'd2,
        EVAL    = 3'd3,
        SCAN    = 3'd4
    } estado_e;

    function automatic logic [N_SLOTS-1:0] one_hot(input logic [POS_W-1:0] idx);
        logic [N_SLOTS-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/asignador_posicion_if.sv
// ---------------------------------------------------------------------------
// asignador_posicion_if
// Bundles every non-clock signal of the allocator.
//   master : game/control logic plus the random-position generator
//            (drives solicitar, liberar, liberar_pos, posicion_in)
//   slave  : the allocator itself
//            (drives pedir, listo, fallo, posicion_out, ocupados, lleno)
// ---------------------------------------------------------------------------
interface asignador_posicion_if;
    import asignador_posicion_pkg::*;

    logic               solicitar;
    logic               liberar;
    logic [POS_W-1:0]   liberar_pos;
    logic               pedir;
    logic [POS_W-1:0]   posicion_in;
    logic               listo;
    logic               fallo;
    logic [POS_W-1:0]   posicion_out;
    logic [N_SLOTS-1:0] ocupados;
    logic               lleno;

    modport master (
        output solicitar, liberar, liberar_pos, posicion_in,
        input  pedir, listo, fallo, posicion_out, ocupados, lleno
    );

    modport slave (
        input  solicitar, liberar, liberar_pos, posicion_in,
        output pedir, listo, fallo, posicion_out, ocupados, lleno
    );

endinterface

// File: rtl/asignador_posicion_mapa_ocupacion.sv
// ---------------------------------------------------------------------------
// mapa_ocupacion
// 16-bit occupancy register. Each cycle a release clears one bit and a grant
// sets one bit; when both hit the same slot the grant wins.
//   clk, rst_n      : clock, asynchronous active-low reset (map clears)
//   liberar_i       : release strobe
//   liberar_pos_i   : slot released
//   grant_i         : grant strobe from the allocator FSM
//   grant_pos_i     : slot granted
//   ocupados_o      : registered map, bit i = slot i in use
//   lleno_o         : all slots in use (combinational)
// ---------------------------------------------------------------------------
module mapa_ocupacion
    import asignador_posicion_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               liberar_i,
    input  logic [POS_W-1:0]   liberar_pos_i,
    input  logic               grant_i,
    input  logic [POS_W-1:0]   grant_pos_i,
    output logic [N_SLOTS-1:0] ocupados_o,
    output logic               lleno_o
);

    logic [N_SLOTS-1:0] ocupados_q;
    logic [N_SLOTS-1:0] ocupados_d;
    logic [N_SLOTS-1:0] relMask;
    logic [N_SLOTS-1:0] grantMask;

    always_comb begin
        relMask    = liberar_i ? one_hot(liberar_pos_i) : '0;
        grantMask  = grant_i   ? one_hot(grant_pos_i)   : '0;
        ocupados_d = (ocupados_q & ~relMask) | grantMask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ocupados_q <= '0;
        end else begin
            ocupados_q <= ocupados_d;
        end
    end

    assign ocupados_o = ocupados_q;
    assign lleno_o    = &ocupados_q;

endmodule

// File: rtl/asignador_posicion.sv
// ---------------------------------------------------------------------------
// asignador_posicion
// Allocates free slots out of a 16-entry map using a random-position
// generator. A request draws positions (pedir pulse, capture, evaluate)
// until a free one is found or MAX_REINTENTOS draws have been spent.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : asignador_posicion_if.slave (request, release, generator
//                handshake, grant/fail pulses, map and full flag)
// Parameter MAX_REINTENTOS (1..255): draws allowed per request.
// Optional macro ASIGNADOR_LINEAR_PROBE_EN: when defined, running out of
// draws starts a linear probe from the last drawn slot instead of failing,
// so a grant is guaranteed whenever some slot is free.
// ---------------------------------------------------------------------------
module asignador_posicion
    import asignador_posicion_pkg::*;
#(
    parameter int MAX_REINTENTOS = 8
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    asignador_posicion_if.slave  bus
);

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_PEDIR   = PEDIR;
    localparam logic [2:0] ST_CAPTURA = CAPTURA;
    localparam logic [2:0] ST_EVAL    = EVAL;
`ifdef ASIGNADOR_LINEAR_PROBE_EN
    localparam logic [2:0] ST_SCAN    = SCAN;
`endif

    logic [2:0]         state_q,   state_d;
    logic [7:0]         intento_q, intento_d;
    logic [POS_W-1:0]   cand_q,    cand_d;
    logic [POS_W-1:0]   pos_q,     pos_d;
    logic               listo_q,   listo_d;
    logic               fallo_q,   fallo_d;
`ifdef ASIGNADOR_LINEAR_PROBE_EN
    logic [POS_W-1:0]   probe_q,    probe_d;
    logic [POS_W-1:0]   probeCnt_q, probeCnt_d;
`endif

    logic               grant;
    logic [POS_W-1:0]   grantPos;
    logic [8:0]         intentoNext;
    logic [N_SLOTS-1:0] ocupados;
    logic               lleno;

    mapa_ocupacion u_mapa (
        .clk           (clk),
        .rst_n         (rst_n),
        .liberar_i     (bus.liberar),
        .liberar_pos_i (bus.liberar_pos),
        .grant_i       (grant),
        .grant_pos_i   (grantPos),
        .ocupados_o    (ocupados),
        .lleno_o       (lleno)
    );

    // Nine bits so that MAX_REINTENTOS = 255 compares without wrapping.
    assign intentoNext = {1'b0, intento_q} + 9'd1;

    always_comb begin
        state_d   = state_q;
        intento_d = intento_q;
        cand_d    = cand_q;
        pos_d     = pos_q;
        listo_d   = 1'b0;
        fallo_d   = 1'b0;
        grant     = 1'b0;
        grantPos  = cand_q;
`ifdef ASIGNADOR_LINEAR_PROBE_EN
        probe_d    = probe_q;
        probeCnt_d = probeCnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.solicitar) begin
                    if (lleno) begin
                        fallo_d = 1'b1;
                    end else begin
                        intento_d = '0;
                        state_d   = ST_PEDIR;
                    end
                end
            end
            ST_PEDIR: begin
                state_d = ST_CAPTURA;
            end
            ST_CAPTURA: begin
                // The generator latched on the pedir edge, so its output is stable now.
                cand_d  = bus.posicion_in;
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                // Registered map: a release in this very cycle is not seen yet.
                if (!ocupados[cand_q]) begin
                    grant   = 1'b1;
                    pos_d   = cand_q;
                    listo_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    intento_d = intentoNext[7:0];
                    if (intentoNext < 9'(MAX_REINTENTOS)) begin
                        state_d = ST_PEDIR;
                    end else begin
`ifdef ASIGNADOR_LINEAR_PROBE_EN
                        probe_d    = cand_q + 4'd1;
                        probeCnt_d = '0;
                        state_d    = ST_SCAN;
`else
                        fallo_d    = 1'b1;
                        state_d    = ST_IDLE;
`endif
                    end
                end
            end
`ifdef ASIGNADOR_LINEAR_PROBE_EN
            ST_SCAN: begin
                if (!ocupados[probe_q]) begin
                    grant    = 1'b1;
                    grantPos = probe_q;
                    pos_d    = probe_q;
                    listo_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else if (probeCnt_q == 4'd15) begin
                    // All sixteen slots probed busy.
                    fallo_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    probe_d    = probe_q + 4'd1;
                    probeCnt_d = probeCnt_q + 4'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            intento_q <= '0;
            cand_q    <= '0;
            pos_q     <= '0;
            listo_q   <= 1'b0;
            fallo_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            intento_q <= intento_d;
            cand_q    <= cand_d;
            pos_q     <= pos_d;
            listo_q   <= listo_d;
            fallo_q   <= fallo_d;
        end
    end

`ifdef ASIGNADOR_LINEAR_PROBE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_q    <= '0;
            probeCnt_q <= '0;
        end else begin
            probe_q    <= probe_d;
            probeCnt_q <= probeCnt_d;
        end
    end
`endif

    // Decoded from the registered state, so reset drops it immediately.
    assign bus.pedir        = (state_q == ST_PEDIR);
    assign bus.listo        = listo_q;
    assign bus.fallo        = fallo_q;
    assign bus.posicion_out = pos_q;
    assign bus.ocupados     = ocupados;
    assign bus.lleno        = lleno;

endmodule

// File: tb/tb_asignador_posicion.sv
// ---------------------------------------------------------------------------
// tb_asignador_posicion
// Self-checking bench for asignador_posicion. A generator process hands out
// positions from drawQ on every pedir pulse; each request is predicted from
// the allocation rules (draw order, retry timing, optional linear probe)
// and compared with the DUT outcome, latency, pedir count and map.
// Honours ASIGNADOR_LINEAR_PROBE_EN to match the DUT build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_asignador_posicion;
    import asignador_posicion_pkg::*;

    localparam int MAX_R  = 8;
    localparam int BUDGET = 3 * MAX_R + 30;

    logic clk;
    logic rst_n;

    asignador_posicion_if bus();

    asignador_posicion #(.MAX_REINTENTOS(MAX_R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] modelOcc;
    logic [3:0]  modelPos;
    int          drawQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Random-position generator: latches a new value on each pedir pulse.
    always @(negedge clk) begin
        if (bus.pedir === 1'b1) begin
            if (drawQ.size() > 0) bus.posicion_in = 4'(drawQ.pop_front());
            else                  bus.posicion_in = 4'($urandom_range(0, 15));
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One allocation request; relCycle >= 1 also pulses a release of relPos
    // in cycle c+relCycle (c = cycle in which solicitar is high).
    task automatic applyStimulus(input string name, input int relCycle, input logic [3:0] relPos);
        int          expKind;
        int          expLat;
        int          expPedir;
        logic [3:0]  expPos;
        logic [15:0] seen;
        logic [15:0] expOcc;
        int          d;
        int          p;
        int          lat;
        int          pedirs;
        int          kind;
        int          both;

        expKind  = 0;
        expLat   = 0;
        expPedir = 0;
        expPos   = modelPos;
        if (&modelOcc) begin
            expKind = 2;
            expLat  = 1;
        end else begin
            for (int k = 0; k < MAX_R && expKind == 0; k++) begin
                d    = drawQ[k];
                seen = modelOcc;
                if (relCycle >= 1 && relCycle < 3 + 3 * k) seen[relPos] = 1'b0;
                expPedir = k + 1;
                if (!seen[d]) begin
                    expKind = 1;
                    expLat  = 4 + 3 * k;
                    expPos  = 4'(d);
                end
            end
            if (expKind == 0) begin
`ifdef ASIGNADOR_LINEAR_PROBE_EN
                for (int j = 0; j < 16 && expKind == 0; j++) begin
                    p    = (drawQ[MAX_R-1] + 1 + j) % 16;
                    seen = modelOcc;
                    if (relCycle >= 1 && relCycle < 3 * MAX_R + 1 + j) seen[relPos] = 1'b0;
                    if (!seen[p]) begin
                        expKind = 1;
                        expLat  = 3 * MAX_R + 2 + j;
                        expPos  = 4'(p);
                    end
                end
                if (expKind == 0) begin
                    expKind = 2;
                    expLat  = 3 * MAX_R + 17;
                end
`else
                expKind = 2;
                expLat  = 3 * MAX_R + 1;
`endif
            end
        end
        expOcc = modelOcc;
        if (relCycle >= 1 && relCycle < expLat) expOcc[relPos] = 1'b0;
        if (expKind == 1) expOcc[expPos] = 1'b1;
        if (relCycle == expLat) expOcc[relPos] = 1'b0;

        bus.solicitar = 1'b1;
        @(posedge clk); #1;
        bus.solicitar = 1'b0;
        lat    = -1;
        pedirs = 0;
        kind   = 0;
        both   = 0;
        for (int cyc = 1; cyc <= BUDGET && lat < 0; cyc++) begin
            bus.liberar     = (cyc == relCycle);
            bus.liberar_pos = relPos;
            @(negedge clk);
            if (bus.pedir) pedirs++;
            if (bus.listo && bus.fallo) both = 1;
            if (bus.listo || bus.fallo) begin
                lat  = cyc;
                kind = bus.listo ? 1 : 2;
            end
            @(posedge clk); #1;
        end
        bus.liberar = 1'b0;

        checkOutput({name, "_outcome"}, 32'(kind), 32'(expKind));
        checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({name, "_pedirs"}, 32'(pedirs), 32'(expPedir));
        checkOutput({name, "_both"}, 32'(both), 32'd0);
        checkOutput({name, "_pulse"}, {30'd0, bus.listo, bus.fallo}, 32'd0);
        checkOutput({name, "_pos"}, 32'(bus.posicion_out), 32'(expPos));
        checkOutput({name, "_ocupados"}, 32'(bus.ocupados), 32'(expOcc));
        checkOutput({name, "_lleno"}, 32'(bus.lleno), 32'(&expOcc));
        modelOcc = expOcc;
        modelPos = expPos;
    endtask

    task automatic releaseSlot(input logic [3:0] pos);
        bus.liberar     = 1'b1;
        bus.liberar_pos = pos;
        @(posedge clk); #1;
        bus.liberar = 1'b0;
        modelOcc[pos] = 1'b0;
        checkOutput("release_ocupados", 32'(bus.ocupados), 32'(modelOcc));
    endtask

    initial begin
        int pedirsAfter;
        int pulsesAfter;

        rst_n           = 1'b0;
        bus.solicitar   = 1'b0;
        bus.liberar     = 1'b0;
        bus.liberar_pos = '0;
        modelOcc        = '0;
        modelPos        = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_pedir", 32'(bus.pedir), 32'd0);
        checkOutput("reset_listo", 32'(bus.listo), 32'd0);
        checkOutput("reset_fallo", 32'(bus.fallo), 32'd0);
        checkOutput("reset_pos", 32'(bus.posicion_out), 32'd0);
        checkOutput("reset_ocupados", 32'(bus.ocupados), 32'd0);
        checkOutput("reset_lleno", 32'(bus.lleno), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty map, first draw free.
        drawQ.delete(); drawQ.push_back(5);
        applyStimulus("first", -1, 4'd0);

        // Busy draw followed by a free one.
        drawQ.delete(); drawQ.push_back(5); drawQ.push_back(9);
        applyStimulus("retry", -1, 4'd0);

        // Release of slot 5 while EVAL tests it: retry, then 5 is granted.
        drawQ.delete(); drawQ.push_back(5); drawQ.push_back(5);
        applyStimulus("relEval", 3, 4'd5);

        // Occupy slot 3, then keep drawing 3 until the draws run out.
        drawQ.delete(); drawQ.push_back(3);
        applyStimulus("take3", -1, 4'd0);
        drawQ.delete();
        for (int i = 0; i < MAX_R + 2; i++) drawQ.push_back(3);
        applyStimulus("stuck3", -1, 4'd0);

        // Fill the map, then a request on a full map fails without drawing.
        for (int s = 0; s < 16; s++) begin
            if (!modelOcc[s]) begin
                drawQ.delete(); drawQ.push_back(s);
                applyStimulus("fill", -1, 4'd0);
            end
        end
        drawQ.delete(); drawQ.push_back(0);
        applyStimulus("full", -1, 4'd0);

        // Release of an already free slot changes nothing.
        releaseSlot(4'd7);
        releaseSlot(4'd7);

        // Randomized mix of releases and requests.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                releaseSlot(4'($urandom_range(0, 15)));
            end else begin
                drawQ.delete();
                for (int i = 0; i < MAX_R + 2; i++) drawQ.push_back(int'($urandom_range(0, 15)));
                if ($urandom_range(0, 1) == 1)
                    applyStimulus("rnd", int'($urandom_range(1, 12)), 4'($urandom_range(0, 15)));
                else
                    applyStimulus("rnd", -1, 4'd0);
            end
        end

        // Make sure the map is not empty before the reset test.
        if (modelOcc == 16'h0000) begin
            drawQ.delete(); drawQ.push_back(1);
            applyStimulus("preRst", -1, 4'd0);
        end
        if (&modelOcc) releaseSlot(4'd2);

        // Reset asserted while in CAPTURA.
        drawQ.delete(); drawQ.push_back(2);
        bus.solicitar = 1'b1;
        @(posedge clk); #1;
        bus.solicitar = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_pedir", 32'(bus.pedir), 32'd0);
        checkOutput("midrst_ocupados", 32'(bus.ocupados), 32'd0);
        checkOutput("midrst_pos", 32'(bus.posicion_out), 32'd0);
        checkOutput("midrst_pulses", {30'd0, bus.listo, bus.fallo}, 32'd0);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        modelOcc = '0;
        modelPos = '0;
        drawQ.delete();
        pedirsAfter = 0;
        pulsesAfter = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (bus.pedir) pedirsAfter++;
            if (bus.listo || bus.fallo) pulsesAfter++;
        end
        @(posedge clk); #1;
        checkOutput("postrst_pedir", 32'(pedirsAfter), 32'd0);
        checkOutput("postrst_pulses", 32'(pulsesAfter), 32'd0);

        drawQ.delete(); drawQ.push_back(7);
        applyStimulus("afterRst", -1, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
